dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store stage and an auxiliary requester (debug/program loader) that uses a valid/ready handshake.
- Grants at most one access per cycle. The core has priority, and a streak counter guarantees the aux requester cannot starve.
- Tracks the one-cycle synchronous read latency and routes read data back to the requester that issued the read.
- Sits between the memory stage and the data RAM and drives the RAM control pins.

---
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_port_arbiter.sv | 78 +++++++
 tb/tb_dmem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the memory stage, the aux requester and the data RAM.
// The arbiter uses the slave modport; the requesters and RAM model use master.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic [3:0]        core_be;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;

    logic              aux_valid;
    logic              aux_ready;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [31:0]       aux_wdata;
    logic [3:0]        aux_be;
    logic              aux_rvalid;
    logic [31:0]       aux_rdata;

    logic              mem_en;
    logic              mem_wr_en;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_rst;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_be,
        output core_stall, core_rvalid, core_rdata,
        input  aux_valid, aux_we, aux_addr, aux_wdata, aux_be,
        output aux_ready, aux_rvalid, aux_rdata,
        output mem_en, mem_wr_en, mem_be, mem_addr, mem_wr_data, mem_rst,
        input  mem_rd_data
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_be,
        input  core_stall, core_rvalid, core_rdata,
        output aux_valid, aux_we, aux_addr, aux_wdata, aux_be,
        input  aux_ready, aux_rvalid, aux_rdata,
        input  mem_en, mem_wr_en, mem_be, mem_addr, mem_wr_data, mem_rst,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-RAM port: core has priority, a streak
// counter forces the aux requester in, and read data is routed back one cycle later.
module dmem_port_arbiter #(
    parameter int unsigned MAX_CORE_STREAK = 4,
    parameter int unsigned ADDR_W          = 32
) (
    input logic                 Clk,
    input logic                 Reset_n,
    dmem_port_arbiter_if.slave  bus
);
    localparam logic [3:0] StreakMax = 4'(MAX_CORE_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       rd_core_q, rd_core_d;
    logic       rd_aux_q, rd_aux_d;
    logic       core_grant, aux_grant;

    always_comb begin
        aux_grant  = Reset_n & bus.aux_valid & (~bus.core_req | (streak_q == StreakMax));
        core_grant = Reset_n & bus.core_req & ~aux_grant;
    end

    always_comb begin
        bus.core_stall = Reset_n & bus.core_req & ~core_grant;
        bus.aux_ready  = aux_grant;
        bus.mem_en     = core_grant | aux_grant;
        bus.mem_rst    = ~Reset_n;

        bus.mem_wr_en   = 1'b0;
        bus.mem_be      = 4'h0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = 32'h0;
        if (aux_grant) begin
            bus.mem_wr_en   = bus.aux_we;
            bus.mem_be      = bus.aux_we ? bus.aux_be : 4'h0;
            bus.mem_addr    = bus.aux_addr;
            bus.mem_wr_data = bus.aux_wdata;
        end else if (core_grant) begin
            bus.mem_wr_en   = bus.core_we;
            bus.mem_be      = bus.core_we ? bus.core_be : 4'h0;
            bus.mem_addr    = bus.core_addr;
            bus.mem_wr_data = bus.core_wdata;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (aux_grant) begin
            streak_d = 4'h0;
        end else if (core_grant && bus.aux_valid) begin
            streak_d = (streak_q == StreakMax) ? StreakMax : streak_q + 4'h1;
        end else if (!bus.aux_valid) begin
            streak_d = 4'h0;
        end
        rd_core_d = core_grant & ~bus.core_we;
        rd_aux_d  = aux_grant & ~bus.aux_we;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            streak_q  <= 4'h0;
            rd_core_q <= 1'b0;
            rd_aux_q  <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            rd_core_q <= rd_core_d;
            rd_aux_q  <= rd_aux_d;
        end
    end

    // Gating with Reset_n drops a read that was in flight when reset asserted.
    always_comb begin
        bus.core_rvalid = Reset_n & rd_core_q;
        bus.aux_rvalid  = Reset_n & rd_aux_q;
        bus.core_rdata  = bus.core_rvalid ? bus.mem_rd_data : 32'h0;
        bus.aux_rdata   = bus.aux_rvalid ? bus.mem_rd_data : 32'h0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a one-cycle-latency RAM model.
module tb_dmem_port_arbiter;
    logic Clk;
    logic Reset_n;
    int   n_cmp;
    int   n_err;

    dmem_port_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_port_arbiter #(.MAX_CORE_STREAK(4), .ADDR_W(32)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hA5A5};
    endfunction

    initial bus.mem_rd_data = 32'h0;
    always @(posedge Clk) begin
        if (bus.mem_en && !bus.mem_wr_en) bus.mem_rd_data <= ram_val(bus.mem_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 32'h0;
        bus.core_wdata = 32'h0; bus.core_be = 4'h0;
        bus.aux_valid = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = 32'h0;
        bus.aux_wdata = 32'h0; bus.aux_be = 4'h0;
    endtask

    task automatic core_drive(input logic we, input logic [31:0] addr);
        bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr;
        bus.core_wdata = 32'hC0DE0000 | addr; bus.core_be = 4'hF;
    endtask

    task automatic aux_drive(input logic we, input logic [31:0] addr);
        bus.aux_valid = 1'b1; bus.aux_we = we; bus.aux_addr = addr;
        bus.aux_wdata = 32'h12345678; bus.aux_be = 4'hF;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        Reset_n = 1'b0;
        core_drive(1'b0, 32'h100);
        aux_drive(1'b1, 32'h40);
        tick();
        tick();
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_aux_ready", bus.aux_ready, 0);
        check_eq("rst_core_stall", bus.core_stall, 0);
        check_eq("rst_mem_rst", bus.mem_rst, 1);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_rvalid", {bus.core_rvalid, bus.aux_rvalid}, 0);

        Reset_n = 1'b1;
        idle();
        #1;
        check_eq("idle_mem_en", bus.mem_en, 0);
        check_eq("idle_mem_rst", bus.mem_rst, 0);
        tick();

        // Core-only read
        core_drive(1'b0, 32'h100);
        #1;
        check_eq("cr_mem_en", bus.mem_en, 1);
        check_eq("cr_mem_addr", bus.mem_addr, 32'h100);
        check_eq("cr_mem_be_read", bus.mem_be, 0);
        check_eq("cr_stall", bus.core_stall, 0);
        tick();
        idle();
        #1;
        check_eq("cr_rvalid", bus.core_rvalid, 1);
        check_eq("cr_rdata", bus.core_rdata, 32'hDEADBEEF);
        check_eq("cr_aux_rvalid", bus.aux_rvalid, 0);
        tick();
        check_eq("cr_rvalid_once", bus.core_rvalid, 0);
        check_eq("cr_rdata_zero", bus.core_rdata, 0);

        // Aux write with idle core
        aux_drive(1'b1, 32'h40);
        #1;
        check_eq("aw_ready", bus.aux_ready, 1);
        check_eq("aw_wr_en", bus.mem_wr_en, 1);
        check_eq("aw_be", bus.mem_be, 4'hF);
        check_eq("aw_addr", bus.mem_addr, 32'h40);
        check_eq("aw_wdata", bus.mem_wr_data, 32'h12345678);
        tick();
        idle();
        #1;
        check_eq("aw_no_rvalid", bus.aux_rvalid, 0);
        tick();

        // Contention: aux forced in on the fifth cycle
        core_drive(1'b1, 32'h200);
        aux_drive(1'b1, 32'h300);
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("ct_ready_%0d", i), bus.aux_ready, (i == 4));
            check_eq($sformatf("ct_stall_%0d", i), bus.core_stall, (i == 4));
            check_eq($sformatf("ct_addr_%0d", i), bus.mem_addr,
                     (i == 4) ? 32'h300 : 32'h200);
            check_eq($sformatf("ct_no_rvalid_%0d", i), bus.core_rvalid, 0);
            tick();
        end
        idle();
        tick();

        // Interleaved reads: core read at cycle 0, forced aux read at cycle 1
        core_drive(1'b1, 32'h200);
        aux_drive(1'b0, 32'h20);
        for (int i = 0; i < 3; i++) tick();
        core_drive(1'b0, 32'h10);
        #1;
        check_eq("il_c0_ready", bus.aux_ready, 0);
        check_eq("il_c0_addr", bus.mem_addr, 32'h10);
        tick();
        check_eq("il_c1_ready", bus.aux_ready, 1);
        check_eq("il_c1_stall", bus.core_stall, 1);
        check_eq("il_c1_addr", bus.mem_addr, 32'h20);
        check_eq("il_c1_core_rvalid", bus.core_rvalid, 1);
        check_eq("il_c1_core_rdata", bus.core_rdata, 32'h0010A5A5);
        check_eq("il_c1_aux_rvalid", bus.aux_rvalid, 0);
        tick();
        bus.aux_valid = 1'b0;
        #1;
        check_eq("il_c2_aux_rvalid", bus.aux_rvalid, 1);
        check_eq("il_c2_aux_rdata", bus.aux_rdata, 32'h0020A5A5);
        check_eq("il_c2_core_rvalid", bus.core_rvalid, 0);
        check_eq("il_c2_core_rdata", bus.core_rdata, 0);
        tick();
        idle();
        #1;
        check_eq("il_c3_core_rvalid", bus.core_rvalid, 1);
        check_eq("il_c3_aux_rvalid", bus.aux_rvalid, 0);
        tick();

        // Reset while a core read is in flight
        core_drive(1'b0, 32'h100);
        #1;
        check_eq("rr_mem_en", bus.mem_en, 1);
        tick();
        idle();
        Reset_n = 1'b0;
        #1;
        check_eq("rr_rvalid", bus.core_rvalid, 0);
        check_eq("rr_rdata", bus.core_rdata, 0);
        check_eq("rr_mem_en", bus.mem_en, 0);
        check_eq("rr_mem_rst", bus.mem_rst, 1);
        tick();
        Reset_n = 1'b1;
        #1;
        check_eq("rr_after_rvalid", bus.core_rvalid, 0);

        // Aux drop clears the streak; also shows the streak is 0 after reset
        core_drive(1'b1, 32'h200);
        aux_drive(1'b1, 32'h300);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("dr_pre_ready_%0d", i), bus.aux_ready, 0);
            tick();
        end
        bus.aux_valid = 1'b0;
        #1;
        check_eq("dr_gap_stall", bus.core_stall, 0);
        tick();
        bus.aux_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("dr_ready_%0d", i), bus.aux_ready, (i == 4));
            check_eq($sformatf("dr_stall_%0d", i), bus.core_stall, (i == 4));
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
